// File: rtl/rdata_pack_pkg.sv
// Shared types and helpers for the AHB-to-APB read packing sequencer:
// FSM state enum, slice-count derivation and the requested-beat clamp.
package rdata_pack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int calc_num_beats(input int ahb_dw, input int apb_dw);
        return ahb_dw / apb_dw;
    endfunction

    // Zero or an oversize request means a full-width read of every slice.
    function automatic int clamp_last_idx(input int beats, input int num_beats);
        int last_idx;
        if ((beats == 0) || (beats > num_beats)) begin
            last_idx = num_beats - 1;
        end else begin
            last_idx = beats - 1;
        end
        return last_idx;
    endfunction

endpackage

// File: rtl/rdata_beat_cnt.sv
// Beat index counter for the read packer: load/increment, last-beat flag,
// and the one-hot slice load decode qualified by a beat strobe.
module rdata_beat_cnt #(
    parameter int NUM_BEATS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [IDX_W-1:0]     last_in,
    input  logic                 inc,
    input  logic                 strobe,
    output logic [IDX_W-1:0]     idx,
    output logic                 is_last,
    output logic [NUM_BEATS-1:0] onehot
);

    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] last_r;

    // Index and final-index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r  <= {IDX_W{1'b0}};
            last_r <= {IDX_W{1'b0}};
        end else if (load) begin
            idx_r  <= {IDX_W{1'b0}};
            last_r <= last_in;
        end else if (inc) begin
            idx_r  <= idx_r + IDX_W'(1);
        end else begin
            idx_r  <= idx_r;
        end
    end

    // One-hot decode, only while a beat is being acknowledged.
    always_comb begin
        onehot = {NUM_BEATS{1'b0}};
        for (int i = 0; i < NUM_BEATS; i++) begin
            onehot[i] = strobe && (idx_r == IDX_W'(i));
        end
    end

    assign idx     = idx_r;
    assign is_last = (idx_r == last_r);

endmodule

// File: rtl/rdata_pack_ctrl.sv
// Splits one wide AHB read into a burst of APB read beats with per-slice load
// strobes. Optional PSLVERR early-abort is enabled by RDATA_PACK_SLVERR_EN.
module rdata_pack_ctrl
    import rdata_pack_pkg::*;
#(
    parameter  int AHB_DW    = 32,
    parameter  int APB_DW    = 8,
    parameter  int AW        = 32,
    localparam int NUM_BEATS = calc_num_beats(AHB_DW, APB_DW),
    localparam int BEATS_W   = $clog2(NUM_BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [AW-1:0]        i_addr,
    input  logic [BEATS_W-1:0]   i_beats,
    input  logic                 i_pready,
    input  logic                 i_pslverr,
    output logic                 o_psel,
    output logic                 o_penable,
    output logic [AW-1:0]        o_paddr,
    output logic [NUM_BEATS-1:0] o_load,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int            IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [AW-1:0] STEP  = AW'(APB_DW / 8);

    state_e               state_r;
    state_e               state_s;
    logic [AW-1:0]        base_r;
    logic                 cnt_load_s;
    logic                 cnt_inc_s;
    logic                 beat_ack_s;
    logic                 is_last_s;
    logic                 err_hit_s;
    logic [IDX_W-1:0]     idx_s;
    logic [IDX_W-1:0]     last_idx_s;

    assign beat_ack_s = (state_r == ACCESS) && i_pready;
    assign last_idx_s = IDX_W'(clamp_last_idx(int'(i_beats), NUM_BEATS));

    rdata_beat_cnt #(
        .NUM_BEATS (NUM_BEATS),
        .IDX_W     (IDX_W)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load_s),
        .last_in (last_idx_s),
        .inc     (cnt_inc_s),
        .strobe  (beat_ack_s),
        .idx     (idx_s),
        .is_last (is_last_s),
        .onehot  (o_load)
    );

`ifdef RDATA_PACK_SLVERR_EN
    logic err_r;

    assign err_hit_s = beat_ack_s && i_pslverr;

    // Sticky error flag, cleared when a new request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (cnt_load_s) begin
            err_r <= 1'b0;
        end else if (err_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_err = (state_r == DONE) && err_r;
`else
    logic unused_pslverr_s;

    assign unused_pslverr_s = i_pslverr;
    assign err_hit_s        = 1'b0;
    assign o_err            = 1'b0;
`endif

    // State and latched base address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            base_r  <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            base_r  <= cnt_load_s ? i_addr : base_r;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_s    = state_r;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s    = SETUP;
                    cnt_load_s = 1'b1;
                end else begin
                    state_s    = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                if (!i_pready) begin
                    state_s = ACCESS;
                end else if (is_last_s || err_hit_s) begin
                    state_s = DONE;
                end else begin
                    state_s   = SETUP;
                    cnt_inc_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Address wraps modulo 2^AW; driven to zero outside the APB transfer.
    assign o_psel    = (state_r == SETUP) || (state_r == ACCESS);
    assign o_penable = (state_r == ACCESS);
    assign o_paddr   = o_psel ? (base_r + (AW'(idx_s) * STEP)) : {AW{1'b0}};
    assign o_busy    = (state_r != IDLE);
    assign o_done    = (state_r == DONE);

endmodule

// File: doc/rdata_pack_ctrl.md
# rdata_pack_ctrl

Sequencer that converts one wide AHB read into a burst of narrow APB read beats. It drives the APB master phase signals (PSEL/PENABLE/PADDR) and issues one-hot load strobes to a bank of APB_DW-wide data registers, so each returned PRDATA beat lands in its own slice of the assembled HRDATA word. It sits in the bridge between the AHB-side request decoder and the HRDATA register bank, and reports completion or error back to the AHB slave FSM.

## Interface
- AHB_DW, 32: AHB data width; must be an integer multiple of APB_DW.
- APB_DW, 8: APB data width, in bits, and width of each register slice.
- AW, 32: address width.
- NUM_BEATS (derived), AHB_DW/APB_DW: number of register slices.
- clk  input  1  bridge clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle request; accepted only in IDLE.
- i_addr  input  AW  byte address of beat 0; latched on accept.
- i_beats  input  clog2(NUM_BEATS)+1  beats requested; latched on accept.
- i_pready  input  1  APB PREADY.
- i_pslverr  input  1  APB PSLVERR; sampled with i_pready.
- o_psel  output  1  APB PSEL.
- o_penable  output  1  APB PENABLE.
- o_paddr  output  AW  APB PADDR.
- o_load  output  NUM_BEATS  one-hot slice load strobe; all zero when idle.
- o_busy  output  1  high from accept until the DONE cycle inclusive.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  error flag; valid with o_done.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: i_start=1 latches i_addr and i_beats, clears beat index k and the error flag, then goes to SETUP. If i_start=0, stay in IDLE.
- SETUP: o_psel=1, o_penable=0, o_paddr = base + k*(APB_DW/8). Always goes to ACCESS next.
- ACCESS: o_psel=1, o_penable=1, o_paddr held.
  - i_pready=0: stay in ACCESS (wait states are unbounded).
  - i_pready=1: o_load[k]=1 combinationally in that same cycle, so the slice captures PRDATA on that edge.
  - After a ready beat: if k is the last beat, go to DONE; otherwise k increments and the FSM returns to SETUP.
- DONE: o_done=1, o_err = latched error flag, then IDLE.
- i_beats=0 or i_beats>NUM_BEATS: treated as NUM_BEATS.
- Address arithmetic is AW bits wide and wraps modulo 2^AW; no carry is reported.
- i_start outside IDLE: ignored (no queuing).
- Reset, including mid-burst: state returns to IDLE and every output goes to 0. Slices already loaded are not cleared by this block.

## Timing
- Reset values: o_psel, o_penable, o_paddr, o_load, o_busy, o_done and o_err are all 0.
- Single beat with zero wait states: i_start sampled at edge 0; SETUP in cycle 1, ACCESS plus load in cycle 2, o_done in cycle 3.
- N beats with W total wait cycles: o_done occurs 2N+W+1 cycles after accept.
- o_load and o_penable&i_pready are mutually aligned; at most one o_load bit is ever high.
- o_psel stays continuously high across beats except on abort.
- A new i_start is accepted no earlier than the cycle after DONE.

## Configuration
- RDATA_PACK_SLVERR_EN defined: i_pslverr=1 with i_pready=1 in ACCESS sets the error flag. That beat's o_load still fires, the remaining beats are skipped, and the FSM goes to DONE with o_err=1.
- RDATA_PACK_SLVERR_EN undefined: i_pslverr is ignored, all beats always complete, and o_err is tied to 0.

## Structure
- Shared package rdata_pack_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/DONE);
  - a beat-count helper function: NUM_BEATS from AHB_DW and APB_DW;
  - the clamp rule for i_beats.
- One sub-module, rdata_beat_cnt, holds the beat index counter with load/increment/last-beat flag and produces the one-hot decode for o_load.
- The FSM, address adder and error flag stay in the top module.

## Test plan
- Reset mid-ACCESS (AHB_DW=32, APB_DW=8, 4 beats, reset asserted during beat 2) -> all outputs 0 immediately; the next i_start runs a clean 4-beat burst.
- 4-beat read at i_addr=0x100, zero wait states -> o_paddr 0x100/0x101/0x102/0x103; o_load 0001/0010/0100/1000; o_done 9 cycles after accept; o_err=0.
- 2-beat read with 3 wait cycles on beat 0 -> o_penable held high through the waits with o_load low; o_done 8 cycles after accept.
- i_beats=0 and i_beats=7 -> both run 4 beats; i_start pulsed while busy -> ignored and no extra beats issued.
- i_addr=0xFFFFFFFE, 4 beats -> o_paddr FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- PSLVERR on beat 1 of 4 with RDATA_PACK_SLVERR_EN defined -> o_load 0001 then 0010, o_done with o_err=1, no beats 2–3. With the macro undefined -> all 4 beats run and o_err=0.
